// File: rtl/dvp_pattern_tx.sv
// DVP (OV5640-style) RGB565 test-pattern source: vsync, then per-line href with
// two bytes per pixel. Outputs are registered one cycle behind the phase FSM.
module dvp_pattern_tx #(
  parameter int IMAGE_WIDTH   = 1280,
  parameter int IMAGE_HEIGHT  = 720,
  parameter int VS_CYCLES     = 64,
  parameter int VBP_CYCLES    = 128,
  parameter int HBLANK_CYCLES = 32,
  parameter int VFP_CYCLES    = 64
) (
  input  logic        clk,
  input  logic        g_rst_p,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE_BYTES = 2 * IMAGE_WIDTH;
  localparam int BAR_BYTES  = IMAGE_WIDTH / 4;
  localparam int MAX_A      = (VS_CYCLES > VBP_CYCLES) ? VS_CYCLES : VBP_CYCLES;
  localparam int MAX_B      = (HBLANK_CYCLES > VFP_CYCLES) ? HBLANK_CYCLES : VFP_CYCLES;
  localparam int MAX_P      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW         = $clog2(MAX_P + 1);
  localparam int XW         = $clog2(LINE_BYTES);
  localparam int YW         = $clog2(IMAGE_HEIGHT + 1);
  localparam int BW         = $clog2(BAR_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_VFP    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]  bar_q, bar_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] solid_q, solid_d;
  logic        vsync_q, vsync_d, href_q, href_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] px_s, yy_s, pix_s;
  logic        unused_ok_s;

  assign px_s        = 16'(x_q >> 1);
  assign yy_s        = 16'(y_q);
  assign unused_ok_s = ^{px_s[15:8], px_s[1:0], yy_s[15:6], yy_s[4:0]};

  // Phase sequencing, pixel position tracking and registered output generation
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    x_d     = x_q;
    y_d     = y_q;
    bcnt_d  = bcnt_q;
    bar_d   = bar_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_VSYNC;
          pat_d   = pattern;
          solid_d = solid_color;
          y_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VSYNC: begin
        if (cnt_q == CW'(VS_CYCLES - 1)) state_d = S_VBP;
        else cnt_d = cnt_q + CW'(1);
      end
      S_VBP, S_HBLANK: begin
        if (cnt_q == ((state_q == S_VBP) ? CW'(VBP_CYCLES - 1) : CW'(HBLANK_CYCLES - 1))) begin
          state_d = S_LINE;
          x_d     = '0;
          bcnt_d  = '0;
          bar_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LINE: begin
        if (x_q == XW'(LINE_BYTES - 1)) begin
          if (y_q == YW'(IMAGE_HEIGHT - 1)) begin
            state_d = S_VFP;
          end else begin
            state_d = S_HBLANK;
            y_d     = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
          // Bar index advances from a byte counter so no divider is needed
          if (bcnt_q == BW'(BAR_BYTES - 1)) begin
            bcnt_d = '0;
            bar_d  = bar_q + 3'd1;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      S_VFP: begin
        if (cnt_q == CW'(VFP_CYCLES - 1)) begin
          y_d = '0;
          if (enable) begin
            state_d = S_VSYNC;
            pat_d   = pattern;
            solid_d = solid_color;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (pat_q)
      2'd0: begin
        case (bar_q)
          3'd0:    pix_s = 16'hFFFF;
          3'd1:    pix_s = 16'hFFE0;
          3'd2:    pix_s = 16'h07FF;
          3'd3:    pix_s = 16'h07E0;
          3'd4:    pix_s = 16'hF81F;
          3'd5:    pix_s = 16'hF800;
          3'd6:    pix_s = 16'h001F;
          default: pix_s = 16'h0000;
        endcase
      end
      2'd1:    pix_s = (px_s[5] ^ yy_s[5]) ? 16'hFFFF : 16'h0000;
      2'd2:    pix_s = {px_s[7:3], px_s[7:2], px_s[7:3]};
      default: pix_s = solid_q;
    endcase

    vsync_d = (state_q == S_VSYNC);
    href_d  = (state_q == S_LINE);
    busy_d  = (state_q != S_IDLE);
    done_d  = (state_q == S_VFP) && (cnt_q == CW'(VFP_CYCLES - 1));
    if (href_d) data_d = x_q[0] ? pix_s[7:0] : pix_s[15:8];
    else data_d = 8'h00;
    if (done_d) fcnt_d = fcnt_q + 16'd1;
    else fcnt_d = fcnt_q;
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (g_rst_p) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bcnt_q  <= '0;
      bar_q   <= 3'd0;
      pat_q   <= 2'd0;
      solid_q <= 16'h0000;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bcnt_q  <= bcnt_d;
      bar_q   <= bar_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign dvp_vsync  = vsync_q;
  assign dvp_href   = href_q;
  assign dvp_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx: expected bytes are queued when a frame is
// requested and popped whenever href is high; timing is checked alongside.
module tb_dvp_pattern_tx;
  localparam int W = 16, H = 4, VS = 4, VBP = 6, HB = 3, VFP = 5, PERIOD = 152;

  logic        clk = 1'b0, g_rst_p = 1'b1, enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        dvp_vsync, dvp_href, busy, frame_done;
  logic [7:0]  dvp_data;
  logic [15:0] frame_cnt;

  int errors = 0, checks = 0;
  logic [7:0] sb_q[$];

  dvp_pattern_tx #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .VS_CYCLES(VS), .VBP_CYCLES(VBP),
    .HBLANK_CYCLES(HB), .VFP_CYCLES(VFP)
  ) dut (
    .clk(clk), .g_rst_p(g_rst_p), .enable(enable), .pattern(pattern),
    .solid_color(solid_color), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href),
    .dvp_data(dvp_data), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int pat, input int x, input int y,
                                          input logic [15:0] solid);
    logic [15:0] xv;
    xv = 16'(x);
    case (pat)
      0: begin
        case (x / (W / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      2: return {xv[7:3], xv[7:2], xv[7:3]};
      default: return solid;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] solid);
    logic [15:0] p;
    for (int y = 0; y < H; y++) begin
      for (int k = 0; k < 2 * W; k++) begin
        p = exp_pix(pat, k >> 1, y, solid);
        sb_q.push_back((k % 2 == 1) ? p[7:0] : p[15:8]);
      end
    end
  endtask

  task automatic wait_done(input int start, output int c);
    c = start;
    do begin
      @(negedge clk);
      c++;
    end while (frame_done !== 1'b1 && c < start + 500);
  endtask

  // Output monitor: scoreboard pop, href/vsync widths, gaps, lines per frame
  int run_len = 0, low_len = 0, lines = 0, vs_len = 0;
  logic href_prev = 1'b0, vs_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (dvp_href === 1'b1) begin
      if (href_prev == 1'b0) begin
        chk("href_gap", 32'(low_len), 32'((lines == 0) ? VBP : HB));
        lines++;
      end
      if (sb_q.size() > 0) chk("data", 32'(dvp_data), 32'(sb_q.pop_front()));
      else chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
      run_len++;
      low_len = 0;
    end else begin
      chk("data_idle", 32'(dvp_data), 32'd0);
      if (href_prev == 1'b1) begin
        chk("href_len", 32'(run_len), 32'(2 * W));
        run_len = 0;
      end
      if (dvp_vsync !== 1'b1) low_len++;
    end
    if (dvp_vsync === 1'b1) begin
      if (vs_prev == 1'b0) begin
        low_len = 0;
        lines   = 0;
      end
      vs_len++;
    end else if (vs_prev == 1'b1) begin
      chk("vsync_len", 32'(vs_len), 32'(VS));
      vs_len = 0;
    end
    if (frame_done === 1'b1) begin
      chk("lines_per_frame", 32'(lines), 32'(H));
      lines = 0;
    end
    href_prev = (dvp_href === 1'b1);
    vs_prev   = (dvp_vsync === 1'b1);
  end

  initial begin
    int k, k2, vs_seen;
    logic [31:0] acc;

    // Reset and idle
    repeat (3) @(negedge clk);
    g_rst_p = 1'b0;
    acc = 32'd0;
    repeat (50) begin
      @(negedge clk);
      acc = acc | {6'd0, dvp_vsync, dvp_href, dvp_data, busy, frame_done, frame_cnt};
    end
    chk("idle_outputs", acc, 32'd0);

    // Single colour-bar frame from a one-clock enable pulse
    pattern = 2'd0;
    enable  = 1'b1;
    push_frame(0, 16'h0000);
    @(negedge clk);
    enable = 1'b0;
    chk("vsync_not_yet", 32'(dvp_vsync), 32'd0);
    @(negedge clk);
    chk("vsync_busy_rise", 32'({dvp_vsync, busy}), 32'd3);
    wait_done(2, k);
    chk("frame_done_at", 32'(k), 32'(PERIOD + 1));
    chk("frame_cnt_1", 32'(frame_cnt), 32'd1);
    chk("busy_last_vfp", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_fall", 32'({busy, frame_done}), 32'd0);
    chk("sb_drained_bars", 32'(sb_q.size()), 32'd0);
    repeat (5) @(negedge clk);

    // Continuous frames with a mid-frame pattern change
    pattern     = 2'd3;
    solid_color = 16'h1234;
    enable      = 1'b1;
    push_frame(3, 16'h1234);
    repeat (20) @(negedge clk);
    pattern = 2'd1;
    push_frame(1, 16'h0000);
    wait_done(20, k);
    chk("frame0_done_at", 32'(k), 32'(PERIOD + 1));
    enable = 1'b0;
    wait_done(0, k2);
    chk("b2b_period", 32'(k2), 32'(PERIOD));
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);
    @(negedge clk);
    chk("busy_after_b2b", 32'(busy), 32'd0);
    chk("sb_drained_b2b", 32'(sb_q.size()), 32'd0);

    // Enable dropped during line 2: frame still completes, then idle
    pattern = 2'd2;
    enable  = 1'b1;
    push_frame(2, 16'h0000);
    repeat (90) @(negedge clk);
    enable = 1'b0;
    wait_done(90, k);
    chk("drop_done_at", 32'(k), 32'(PERIOD + 1));
    chk("frame_cnt_4", 32'(frame_cnt), 32'd4);
    vs_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (dvp_vsync === 1'b1) vs_seen++;
    end
    chk("no_second_vsync", 32'(vs_seen), 32'd0);
    chk("idle_after_drop", 32'(busy), 32'd0);
    chk("sb_drained_ramp", 32'(sb_q.size()), 32'd0);

    // Reset asserted during HBLANK, then a clean restart
    pattern = 2'd0;
    enable  = 1'b1;
    push_frame(0, 16'h0000);
    @(negedge clk);
    enable = 1'b0;
    k = 0;
    while (dvp_href !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    while (dvp_href === 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("hblank_reached", 32'(k < 200), 32'd1);
    g_rst_p = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 32'({dvp_href, dvp_vsync, busy, frame_done}), 32'd0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    g_rst_p = 1'b0;
    sb_q.delete();
    repeat (5) @(negedge clk);
    chk("idle_after_reset", 32'({busy, dvp_href}), 32'd0);
    enable = 1'b1;
    push_frame(0, 16'h0000);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("restart_vsync", 32'(dvp_vsync), 32'd1);
    wait_done(2, k);
    chk("restart_done_at", 32'(k), 32'(PERIOD + 1));
    chk("frame_cnt_restart", 32'(frame_cnt), 32'd1);
    @(negedge clk);
    chk("busy_end", 32'(busy), 32'd0);
    chk("sb_drained_restart", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
